alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator and consumer side of the 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file. It drives the operands onto the ALU's R1/R2 inputs, selects the required ALU result output by opcode, then writes the result and status flags back. It sits between the instruction source (decoder or testbench) and the combinational ALU.

Parameters:
NREGS, 4, number of 8-bit general registers (power of two, 2..16)
AW, 2, register address width, log2(NREGS)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  controller can accept an instruction
in_op  in  3  opcode: 0 ADD, 1 MUL2, 2 DIV2, 3 AND, 4 OR, 5 CMP, 6 LDI, 7 MOV
in_rd  in  AW  destination register, also first operand (R1)
in_rs  in  AW  second operand register (R2)
in_imm  in  8  immediate for LDI
alu_r1  out  8  operand to ALU R1
alu_r2  out  8  operand to ALU R2
alu_add  in  8  ALU Addition
alu_mul2  in  8  ALU MultiplyByTwo
alu_div2  in  8  ALU DivideByTwo
alu_and  in  8  ALU And
alu_or  in  8  ALU Or
alu_cmp  in  8  ALU Compare
alu_add_ovf  in  1  ALU AdditionOverflow
alu_mul2_ovf  in  1  ALU MultiplyByTwoOverflow
done  out  1  one-cycle pulse: writeback complete
flag_z  out  1  zero flag of last written result
flag_v  out  1  overflow flag of last ADD/MUL2
dbg_addr  in  AW  debug read address
dbg_data  out  8  combinational read of reg[dbg_addr]

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; all registers 0x00; alu_r1/alu_r2 0x00; done 0; flag_z 0; flag_v 0. in_ready is 1 after reset, because it decodes IDLE.
- Reset mid-operation aborts the instruction. No register write occurs and no done pulse is produced.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: in_ready=1. When in_valid=1, latch op/rd/rs/imm and go to READ.
  - READ: alu_r1 <= reg[rd]; alu_r2 <= reg[rs]. Then go to EXEC.
  - EXEC: the ALU settles combinationally. Capture the selected result and its overflow into internal result/ovf registers. Then go to WRITE.
  - WRITE: reg[rd] <= result. flag_z <= (result==0). done=1 for this cycle only. Then go to IDLE.
- Latency: handshake accepted in cycle N; done is high in cycle N+3; in_ready returns high in cycle N+4. Throughput is one instruction per 4 cycles. in_ready=0 in READ, EXEC and WRITE; in_valid in those states is ignored.
- Result selection:
  - ADD: alu_add
  - MUL2: alu_mul2 (operates on R2=reg[rs])
  - DIV2: alu_div2 (on reg[rs])
  - AND: alu_and
  - OR: alu_or
  - CMP: alu_cmp
  - LDI: in_imm (ALU ignored)
  - MOV: reg[rs] via alu_r2 (ALU ignored)
- flag_v: updated only on ADD (from alu_add_ovf) and MUL2 (from alu_mul2_ovf). It holds its previous value for all other ops. flag_z is updated on every op.
- rd==rs is legal. Both operands read the same pre-write value, e.g. ADD r1,r1 doubles r1.
- The debug read is combinational. In the WRITE cycle dbg_data shows the old value; the new value is visible from the next cycle.
- Arithmetic is 8-bit with wrap; all overflow detection is done by the ALU.
- alu_r1/alu_r2 hold their values until the next READ.

Optional Feature:
ALU_ISSUE_SAT_EN.
- Defined: on ADD or MUL2 with the corresponding overflow input high, the written result is 0xFF (saturate) instead of the ALU value. flag_v is still set, and flag_z is computed on 0xFF (so 0).
- Undefined: the wrapped ALU value is written unchanged.

Test Plan:
- Reset: rst_n low with random inputs -> in_ready=1, done=0, flags 0, dbg_data=0x00 for every register address.
- LDI r0,0x05; LDI r1,0x07; ADD r0,r1 -> done 3 cycles after each accept, alu_r1=0x05, alu_r2=0x07, r0=0x0C, flag_z=0, flag_v=0.
- LDI r2,0xC8; LDI r3,0x64; ADD r2,r3 with the ALU model flagging overflow -> r2=0x2C and flag_v=1 (macro off); r2=0xFF and flag_v=1 (ALU_ISSUE_SAT_EN defined).
- LDI r1,0x80; MUL2 r0,r1 -> r0=0x00, flag_z=1, flag_v=1. Then DIV2 r0,r1 -> r0=0x40, flag_v stays 1.
- Handshake: hold in_valid=1 continuously with 3 queued ops -> exactly one accept per 4 cycles, in_ready low in READ/EXEC/WRITE, exactly 3 done pulses.
- Pull rst_n low during EXEC of ADD r0,r1 -> no done pulse, all registers 0x00 after release, next instruction accepted normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller for an external combinational 8-bit ALU.
// It accepts one instruction at a time, reads operands from a small register file,
// drives them to the ALU, picks the ALU output that matches the opcode, and writes
// the result and flags back.
// Optional feature macro: ALU_ISSUE_SAT_EN. When it is defined, an ADD or MUL2 that
// overflows writes 0xFF instead of the wrapped value.
module alu_issue_ctrl #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [7:0]    in_imm,
  output logic [7:0]    alu_r1,
  output logic [7:0]    alu_r2,
  input  logic [7:0]    alu_add,
  input  logic [7:0]    alu_mul2,
  input  logic [7:0]    alu_div2,
  input  logic [7:0]    alu_and,
  input  logic [7:0]    alu_or,
  input  logic [7:0]    alu_cmp,
  input  logic          alu_add_ovf,
  input  logic          alu_mul2_ovf,
  output logic          done,
  output logic          flag_z,
  output logic          flag_v,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpMul2 = 3'd1;
  localparam logic [2:0] OpDiv2 = 3'd2;
  localparam logic [2:0] OpAnd  = 3'd3;
  localparam logic [2:0] OpOr   = 3'd4;
  localparam logic [2:0] OpCmp  = 3'd5;
  localparam logic [2:0] OpLdi  = 3'd6;
  localparam logic [2:0] OpMov  = 3'd7;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs_q;
  logic [7:0]    imm_q;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    r1_q, r2_q;
  logic [7:0]    result_q, res_sel;
  logic          ovf_q, ovf_sel;
  logic          flag_z_q, flag_v_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state: fixed four-cycle walk once an instruction is accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Latch the instruction fields on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      imm_q <= '0;
    end else if (state_q == StIdle && in_valid) begin
      op_q  <= in_op;
      rd_q  <= in_rd;
      rs_q  <= in_rs;
      imm_q <= in_imm;
    end
  end

  // Operand registers: loaded in READ, held until the next READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
    end else if (state_q == StRead) begin
      r1_q <= regs_q[rd_q];
      r2_q <= regs_q[rs_q];
    end
  end

  // Result select by opcode; only ADD and MUL2 can report overflow
  always_comb begin
    res_sel = '0;
    ovf_sel = 1'b0;
    unique case (op_q)
      OpAdd:  begin res_sel = alu_add;  ovf_sel = alu_add_ovf;  end
      OpMul2: begin res_sel = alu_mul2; ovf_sel = alu_mul2_ovf; end
      OpDiv2: res_sel = alu_div2;
      OpAnd:  res_sel = alu_and;
      OpOr:   res_sel = alu_or;
      OpCmp:  res_sel = alu_cmp;
      OpLdi:  res_sel = imm_q;
      OpMov:  res_sel = r2_q;
      default: res_sel = '0;
    endcase
`ifdef ALU_ISSUE_SAT_EN
    if (ovf_sel) res_sel = 8'hFF;
`endif
  end

  // Capture the settled ALU output in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (state_q == StExec) begin
      result_q <= res_sel;
      ovf_q    <= ovf_sel;
    end
  end

  // Writeback of register file and flags in WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else if (state_q == StWrite) begin
      regs_q[rd_q] <= result_q;
      flag_z_q     <= (result_q == 8'h00);
      // flag_v tracks only the ops that can overflow
      if (op_q == OpAdd || op_q == OpMul2) flag_v_q <= ovf_q;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign done     = (state_q == StWrite);
  assign alu_r1   = r1_q;
  assign alu_r2   = r2_q;
  assign flag_z   = flag_z_q;
  assign flag_v   = flag_v_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a scoreboard.
module tb_alu_issue_ctrl;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [AW-1:0] in_rd = '0, in_rs = '0;
  logic [7:0]    in_imm = '0;
  logic [7:0]    alu_r1, alu_r2;
  logic [7:0]    alu_add, alu_mul2, alu_div2, alu_and, alu_or, alu_cmp;
  logic          alu_add_ovf, alu_mul2_ovf;
  logic          done, flag_z, flag_v;
  logic [AW-1:0] dbg_addr = '0;
  logic [7:0]    dbg_data;

  alu_issue_ctrl #(.NREGS(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_add(alu_add), .alu_mul2(alu_mul2),
    .alu_div2(alu_div2), .alu_and(alu_and), .alu_or(alu_or), .alu_cmp(alu_cmp),
    .alu_add_ovf(alu_add_ovf), .alu_mul2_ovf(alu_mul2_ovf), .done(done),
    .flag_z(flag_z), .flag_v(flag_v), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU
  function automatic logic [7:0] cmp_f(input logic [7:0] a, input logic [7:0] b);
    if (a == b)     return 8'h00;
    else if (a > b) return 8'h01;
    else            return 8'hFF;
  endfunction

  logic [8:0] add_sum;
  assign add_sum      = {1'b0, alu_r1} + {1'b0, alu_r2};
  assign alu_add      = add_sum[7:0];
  assign alu_add_ovf  = add_sum[8];
  assign alu_mul2     = {alu_r2[6:0], 1'b0};
  assign alu_mul2_ovf = alu_r2[7];
  assign alu_div2     = {1'b0, alu_r2[7:1]};
  assign alu_and      = alu_r1 & alu_r2;
  assign alu_or       = alu_r1 | alu_r2;
  assign alu_cmp      = cmp_f(alu_r1, alu_r2);

  // Reference architectural state and scoreboard
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [7:0]    old_val;
    logic [7:0]    val;
    logic          z;
    logic          v;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m [4];
  logic       m_z, m_v;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    m_z = 1'b0;
    m_v = 1'b0;
  endtask

  // Compute the expected writeback and push it onto the scoreboard
  task automatic model_push(input logic [2:0] op, input logic [AW-1:0] rd,
                            input logic [AW-1:0] rs, input logic [7:0] imm);
    exp_t       e;
    logic [7:0] a, b, r;
    logic [8:0] s;
    logic       ov, has_v;
    a = m[rd]; b = m[rs]; ov = 1'b0; has_v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; ov = s[8]; has_v = 1'b1; end
      3'd1: begin r = b << 1; ov = b[7]; has_v = 1'b1; end
      3'd2: r = b >> 1;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = cmp_f(a, b);
      3'd6: r = imm;
      default: r = b;
    endcase
`ifdef ALU_ISSUE_SAT_EN
    if (ov) r = 8'hFF;
`endif
    m_z = (r == 8'h00);
    if (has_v) m_v = ov;
    e.rd = rd; e.old_val = a; e.val = r; e.z = m_z; e.v = m_v;
    m[rd] = r;
    sb_q.push_back(e);
  endtask

  // Issue one instruction from IDLE and check its writeback
  task automatic run_op(input string nm, input logic [2:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs, input logic [7:0] imm);
    exp_t e;
    int   cyc;
    bit   got;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s ready_idle: got %b want 1", nm, in_ready);
    else pass_cnt++;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_imm = imm;
    model_push(op, rd, rs, imm);
    @(posedge clk);
    #1 in_valid = 1'b0; in_op = 3'($urandom); in_imm = 8'($urandom);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1'b1;
    end
    e = sb_q.pop_front();
    chk_cnt++;
    if (!got || cyc != 3) begin
      $display("FAIL %s done_latency: got %0d cycles (seen=%b) want 3", nm, cyc, got);
      return;
    end
    pass_cnt++;
    dbg_addr = e.rd;
    #1;
    chk_cnt++;
    if (dbg_data !== e.old_val || in_ready !== 1'b0)
      $display("FAIL %s write_cycle: dbg=%h ready=%b want dbg=%h ready=0",
               nm, dbg_data, in_ready, e.old_val);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s after_write: done=%b ready=%b want 0/1", nm, done, in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (dbg_data !== e.val) $display("FAIL %s result: got %h want %h", nm, dbg_data, e.val);
    else pass_cnt++;
    chk_cnt++;
    if (flag_z !== e.z || flag_v !== e.v)
      $display("FAIL %s flags: got z=%b v=%b want z=%b v=%b", nm, flag_z, flag_v, e.z, e.v);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_op = 3'($urandom); in_rd = 2'($urandom);
      in_rs = 2'($urandom); in_imm = 8'($urandom);
    end
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1 || done !== 1'b0 || flag_z !== 1'b0 || flag_v !== 1'b0)
      $display("FAIL reset_ctrl: ready=%b done=%b z=%b v=%b want 1/0/0/0",
               in_ready, done, flag_z, flag_v);
    else pass_cnt++;
    chk_cnt++;
    if (alu_r1 !== 8'h00 || alu_r2 !== 8'h00)
      $display("FAIL reset_operands: r1=%h r2=%h want 00/00", alu_r1, alu_r2);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk_cnt++;
      if (dbg_data !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", i, dbg_data);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_add_basic();
    run_op("ldi_r0", 3'd6, 2'd0, 2'd0, 8'h05);
    run_op("ldi_r1", 3'd6, 2'd1, 2'd0, 8'h07);
    run_op("add_r0_r1", 3'd0, 2'd0, 2'd1, 8'h00);
    chk_cnt++;
    if (alu_r1 !== 8'h05 || alu_r2 !== 8'h07)
      $display("FAIL add_operands: r1=%h r2=%h want 05/07", alu_r1, alu_r2);
    else pass_cnt++;
  endtask

  task automatic test_add_ovf();
    run_op("ldi_r2", 3'd6, 2'd2, 2'd0, 8'hC8);
    run_op("ldi_r3", 3'd6, 2'd3, 2'd0, 8'h64);
    run_op("add_ovf", 3'd0, 2'd2, 2'd3, 8'h00);
  endtask

  task automatic test_mul2_div2();
    run_op("ldi_r1_80", 3'd6, 2'd1, 2'd0, 8'h80);
    run_op("mul2_r0_r1", 3'd1, 2'd0, 2'd1, 8'h00);
    run_op("div2_r0_r1", 3'd2, 2'd0, 2'd1, 8'h00);
  endtask

  task automatic test_logic_ops();
    run_op("and_r2_r3", 3'd3, 2'd2, 2'd3, 8'h00);
    run_op("or_r0_r1", 3'd4, 2'd0, 2'd1, 8'h00);
    run_op("cmp_r1_r0", 3'd5, 2'd1, 2'd0, 8'h00);
    run_op("mov_r2_r1", 3'd7, 2'd2, 2'd1, 8'h00);
    run_op("add_r3_r3", 3'd0, 2'd3, 2'd3, 8'h00);
    run_op("add_r2_r2", 3'd0, 2'd2, 2'd2, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [2:0]    ops [3] = '{3'd6, 3'd0, 3'd2};
    logic [AW-1:0] rds [3] = '{2'd0, 2'd0, 2'd1};
    logic [AW-1:0] rss [3] = '{2'd0, 2'd3, 2'd0};
    logic [7:0]    imms[3] = '{8'h3C, 8'h00, 8'h00};
    exp_t pe;
    bit   pend = 1'b0, acc;
    int   idx = 0, dones = 0, last_acc = -1, cyc = 0;
    bit   exp_rdy, exp_done;
    @(negedge clk);
    in_valid = 1'b1; in_op = ops[0]; in_rd = rds[0]; in_rs = rss[0]; in_imm = imms[0];
    while (dones < 3 && cyc < 40) begin
      exp_rdy  = (last_acc < 0) || (cyc - last_acc >= 4);
      exp_done = (last_acc >= 0) && (cyc - last_acc == 3);
      chk_cnt++;
      if (in_ready !== exp_rdy || done !== exp_done)
        $display("FAIL b2b_cycle%0d: ready=%b done=%b want %b/%b",
                 cyc, in_ready, done, exp_rdy, exp_done);
      else pass_cnt++;
      if (pend) begin
        chk_cnt++;
        if (dbg_data !== pe.val || flag_z !== pe.z || flag_v !== pe.v)
          $display("FAIL b2b_wb%0d: dbg=%h z=%b v=%b want %h/%b/%b",
                   dones, dbg_data, flag_z, flag_v, pe.val, pe.z, pe.v);
        else pass_cnt++;
        pend = 1'b0;
      end
      if (done === 1'b1 && sb_q.size() > 0) begin
        pe = sb_q.pop_front();
        dones++;
        dbg_addr = pe.rd;
        pend = 1'b1;
      end
      acc = (in_ready === 1'b1) && in_valid;
      if (acc) begin
        last_acc = cyc;
        model_push(ops[idx], rds[idx], rss[idx], imms[idx]);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == 3) in_valid = 1'b0;
        else begin
          in_op = ops[idx]; in_rd = rds[idx]; in_rs = rss[idx]; in_imm = imms[idx];
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk_cnt++;
    if (idx != 3 || dones != 3)
      $display("FAIL b2b_counts: accepts=%0d dones=%0d want 3/3", idx, dones);
    else pass_cnt++;
    if (pend) begin
      chk_cnt++;
      if (dbg_data !== pe.val || flag_z !== pe.z || flag_v !== pe.v)
        $display("FAIL b2b_last_wb: dbg=%h z=%b v=%b want %h/%b/%b",
                 dbg_data, flag_z, flag_v, pe.val, pe.z, pe.v);
      else pass_cnt++;
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 2'd0; in_rs = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);   // READ
    @(negedge clk);   // EXEC
    rst_n = 1'b0;
    #1;
    if (done === 1'b1) dn++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    chk_cnt++;
    if (dn != 0) $display("FAIL abort_done: got %0d pulses want 0", dn);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk_cnt++;
      if (dbg_data !== 8'h00) $display("FAIL abort_reg%0d: got %h want 00", i, dbg_data);
      else pass_cnt++;
    end
    run_op("post_abort_ldi", 3'd6, 2'd3, 2'd0, 8'h11);
    run_op("post_abort_add", 3'd0, 2'd3, 2'd3, 8'h00);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_basic();
    test_add_ovf();
    test_mul2_div2();
    test_logic_ops();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
